// File: rtl/led_fade_pwm.sv
// -----------------------------------------------------------------------------
// led_fade_pwm
//
// Afterglow stage for the running-light generator. Each of the four LED
// channels is driven at full brightness while its (active-low) input is
// asserted. When the input is released, the channel brightness ramps down
// linearly, one DECAY_STEP per prescaled decay tick. The brightness is shown
// on the LED through a shared PWM counter. In bypass mode the registered input
// pattern is passed straight through to the LEDs.
//
// Ports:
//   sys_clk    in   1  system clock (50 MHz)
//   sys_rst_n  in   1  asynchronous active-low reset
//   led_in     in   4  LED pattern from upstream, active-low, sync to sys_clk
//   fade_en    in   1  1 = fade/PWM drive, 0 = registered bypass
//   led_out    out  4  LED drive, active-low, registered
//
// Parameters:
//   PWM_W       brightness / PWM counter width; PWM period is 2^PWM_W-1 cycles
//   DECAY_MAX   decay prescaler terminal count (tick every DECAY_MAX+1 cycles)
//   DECAY_STEP  brightness decrement applied on each decay tick
// -----------------------------------------------------------------------------
module led_fade_pwm #(
    parameter int unsigned       PWM_W      = 8,
    parameter logic [23:0]       DECAY_MAX  = 24'd97_655,
    parameter logic [PWM_W-1:0]  DECAY_STEP = 8'd1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] led_in,
    input  logic       fade_en,
    output logic [3:0] led_out
);

    localparam logic [PWM_W-1:0] BRI_FULL = '1;
    localparam logic [PWM_W-1:0] PWM_ONE  = {{(PWM_W-1){1'b0}}, 1'b1};
    // The PWM counter stops one short of all-ones so that a full-scale
    // brightness (all-ones) is strictly greater than every counter value,
    // giving a true 100% on-time.
    localparam logic [PWM_W-1:0] PWM_TOP  = BRI_FULL - PWM_ONE;

    logic [3:0]       led_in_d;
    logic [PWM_W-1:0] pwm_cnt;
    logic [23:0]      decay_cnt;
    logic             decay_tick;
    logic [PWM_W-1:0] bri     [4];
    logic [PWM_W-1:0] bri_nxt [4];
    logic [3:0]       led_nxt;

    // -------------------------------------------------------------------------
    // Input register
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led_in_d <= 4'b1111;
        end else begin
            led_in_d <= led_in;
        end
    end

    // -------------------------------------------------------------------------
    // Shared PWM counter: 0 .. 2^PWM_W-2, then wrap
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pwm_cnt <= '0;
        end else if (pwm_cnt == PWM_TOP) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Shared decay prescaler: 0 .. DECAY_MAX, then wrap
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            decay_cnt <= '0;
        end else if (decay_cnt == DECAY_MAX) begin
            decay_cnt <= '0;
        end else begin
            decay_cnt <= decay_cnt + 24'd1;
        end
    end

    assign decay_tick = (decay_cnt == DECAY_MAX);

    // -------------------------------------------------------------------------
    // Per-channel brightness
    // An active input always wins, so a re-trigger landing on a decay tick
    // still snaps back to full scale. The decrement saturates at zero.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bri_nxt[i] = bri[i];
            if (!led_in_d[i]) begin
                bri_nxt[i] = BRI_FULL;
            end else if (decay_tick) begin
                if (bri[i] >= DECAY_STEP) begin
                    bri_nxt[i] = bri[i] - DECAY_STEP;
                end else begin
                    bri_nxt[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < 4; i++) begin
                bri[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                bri[i] <= bri_nxt[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output drive
    // Brightness keeps tracking in bypass mode, so switching fade_en on shows
    // the current afterglow with no jump.
    // -------------------------------------------------------------------------
    always_comb begin
        led_nxt = led_in_d;
        if (fade_en) begin
            for (int i = 0; i < 4; i++) begin
                led_nxt[i] = ~(bri[i] > pwm_cnt);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led_out <= 4'b1111;
        end else begin
            led_out <= led_nxt;
        end
    end

endmodule

// File: tb/tb_led_fade_pwm.sv
// -----------------------------------------------------------------------------
// tb_led_fade_pwm
//
// Directed bench for led_fade_pwm. Three instances:
//   dut_a  DECAY_MAX=3,    DECAY_STEP=64   fast decay, main scenarios
//   dut_b  DECAY_MAX=3,    DECAY_STEP=100  same stimulus, saturation case
//   dut_c  DECAY_MAX=1023, DECAY_STEP=64   slow decay, PWM duty measurement
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_led_fade_pwm;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       fade_en;
    logic [3:0] led_in;
    logic [3:0] led_in_c;
    logic [3:0] led_out_a;
    logic [3:0] led_out_b;
    logic [3:0] led_out_c;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 sys_clk = ~sys_clk;

    led_fade_pwm #(.PWM_W(8), .DECAY_MAX(24'd3), .DECAY_STEP(8'd64)) dut_a (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .led_in   (led_in),
        .fade_en  (fade_en),
        .led_out  (led_out_a)
    );

    led_fade_pwm #(.PWM_W(8), .DECAY_MAX(24'd3), .DECAY_STEP(8'd100)) dut_b (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .led_in   (led_in),
        .fade_en  (fade_en),
        .led_out  (led_out_b)
    );

    led_fade_pwm #(.PWM_W(8), .DECAY_MAX(24'd1023), .DECAY_STEP(8'd64)) dut_c (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .led_in   (led_in_c),
        .fade_en  (fade_en),
        .led_out  (led_out_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // Advance until dut_a channel 0 brightness leaves prev (bounded).
    task automatic wait_a_change(input logic [7:0] prev, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (dut_a.bri[0] == prev && n < 12);
    endtask

    task automatic wait_c_value(input logic [7:0] v);
        int n;
        n = 0;
        while (dut_c.bri[0] != v && n < 1100) begin
            tick(1);
            n++;
        end
    endtask

    task automatic count_lows_c(output int lows);
        lows = 0;
        repeat (255) begin
            tick(1);
            if (!led_out_c[0]) lows++;
        end
    endtask

    initial begin
        int n;
        int bad;
        int bad_b;
        int lows;
        logic [3:0] seq [4];
        logic [3:0] prev;
        logic [7:0] lvl [4];

        sys_rst_n = 1'b0;
        fade_en   = 1'b1;
        led_in    = 4'b1111;
        led_in_c  = 4'b1111;

        // ---------------- Scenario 1: reset ----------------
        tick(3);
        check("rst_led_out", 32'(led_out_a), 32'(4'b1111));
        check("rst_pwm_cnt", 32'(dut_a.pwm_cnt), 32'd0);
        sys_rst_n = 1'b1;
        tick(5);
        check("idle_led_out", 32'(led_out_a), 32'(4'b1111));
        check("idle_bri0", 32'(dut_a.bri[0]), 32'd0);

        led_in = 4'b0000;
        tick(4);
        check("all_on", 32'(led_out_a), 32'(4'b0000));

        #3 sys_rst_n = 1'b0;
        #1;
        check("async_rst_led_out", 32'(led_out_a), 32'(4'b1111));
        check("async_rst_bri3", 32'(dut_a.bri[3]), 32'd0);
        check("async_rst_pwm", 32'(dut_a.pwm_cnt), 32'd0);
        check("async_rst_decay", 32'(dut_a.decay_cnt), 32'd0);
        led_in = 4'b1111;
        tick(2);
        sys_rst_n = 1'b1;
        tick(6);
        check("post_rst_idle", 32'(led_out_a), 32'(4'b1111));
        check("post_rst_bri0", 32'(dut_a.bri[0]), 32'd0);

        // ---------------- Scenario 2: hold channel 0 ----------------
        led_in = 4'b1110;
        tick(1);
        check("lat_k1", 32'(led_out_a), 32'(4'b1111));
        tick(1);
        check("lat_k2", 32'(led_out_a), 32'(4'b1111));
        check("bri_k2", 32'(dut_a.bri[0]), 32'd255);
        tick(1);
        check("lat_k3", 32'(led_out_a), 32'(4'b1110));
        bad = 0;
        repeat (600) begin
            tick(1);
            if (led_out_a !== 4'b1110) bad++;
        end
        check("hold_600", 32'(bad), 32'd0);
        check("hold_bri_b", 32'(dut_b.bri[0]), 32'd255);

        // ---------------- Scenario 3/4/5: release, re-trigger, saturation ----
        led_in = 4'b1111;
        wait_a_change(8'd255, n);
        check("dec1_a", 32'(dut_a.bri[0]), 32'd191);
        check("dec1_b", 32'(dut_b.bri[0]), 32'd155);
        wait_a_change(8'd191, n);
        check("dec_period", 32'(n), 32'd4);
        check("dec2_a", 32'(dut_a.bri[0]), 32'd127);
        check("dec2_b", 32'(dut_b.bri[0]), 32'd55);

        led_in = 4'b1110;
        tick(1);
        led_in = 4'b1111;
        check("retrig_k1", 32'(dut_a.bri[0]), 32'd127);
        tick(1);
        check("retrig_k2_a", 32'(dut_a.bri[0]), 32'd255);
        check("retrig_k2_b", 32'(dut_b.bri[0]), 32'd255);

        wait_a_change(8'd255, n);
        check("regen_first_n", 32'(n), 32'd2);
        check("regen_191", 32'(dut_a.bri[0]), 32'd191);
        check("regen_b155", 32'(dut_b.bri[0]), 32'd155);
        wait_a_change(8'd191, n);
        check("regen_127_n", 32'(n), 32'd4);
        check("regen_127", 32'(dut_a.bri[0]), 32'd127);
        check("regen_b55", 32'(dut_b.bri[0]), 32'd55);
        wait_a_change(8'd127, n);
        check("regen_63_n", 32'(n), 32'd4);
        check("regen_63", 32'(dut_a.bri[0]), 32'd63);
        check("sat_b0", 32'(dut_b.bri[0]), 32'd0);
        wait_a_change(8'd63, n);
        check("regen_0_n", 32'(n), 32'd4);
        check("regen_0", 32'(dut_a.bri[0]), 32'd0);
        check("others_off", 32'(led_out_a[3:1]), 32'(3'b111));

        // Just after a decay tick here; 20 cycles later is again a tick edge.
        bad   = 0;
        bad_b = 0;
        repeat (20) begin
            tick(1);
            if (led_out_a[0] !== 1'b1) bad++;
            if (dut_b.bri[0] !== 8'd0) bad_b++;
        end
        check("faded_off", 32'(bad), 32'd0);
        check("sat_hold_b", 32'(bad_b), 32'd0);
        check("sat_hold_a", 32'(dut_a.bri[0]), 32'd0);

        // ---------------- Scenario 6: bypass then switch to fade -------------
        fade_en = 1'b0;
        tick(4);   // lands just after a decay tick edge (S)
        check("byp_idle", 32'(led_out_a), 32'(4'b1111));
        seq[0] = 4'b1110;
        seq[1] = 4'b1101;
        seq[2] = 4'b1011;
        seq[3] = 4'b0111;
        prev   = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            led_in = seq[i];
            tick(1);
            check("byp_seq", 32'(led_out_a), 32'(prev));
            prev = seq[i];
        end
        tick(1);   // S+5
        check("byp_last", 32'(led_out_a), 32'(4'b0111));
        check("byp_bri0", 32'(dut_a.bri[0]), 32'd191);
        check("byp_bri1", 32'(dut_a.bri[1]), 32'd191);
        check("byp_bri2", 32'(dut_a.bri[2]), 32'd255);
        check("byp_bri3", 32'(dut_a.bri[3]), 32'd255);

        fade_en = 1'b1;
        tick(1);   // S+6
        check("sw_bri0", 32'(dut_a.bri[0]), 32'd191);
        check("sw_bri2", 32'(dut_a.bri[2]), 32'd255);
        check("sw_led32", 32'(led_out_a[3:2]), 32'(2'b00));
        tick(2);   // S+8, decay tick
        check("sw_tick_bri0", 32'(dut_a.bri[0]), 32'd127);
        check("sw_tick_bri1", 32'(dut_a.bri[1]), 32'd127);
        check("sw_tick_bri2", 32'(dut_a.bri[2]), 32'd191);
        check("sw_tick_bri3", 32'(dut_a.bri[3]), 32'd255);
        check("sw_tick_b_bri2", 32'(dut_b.bri[2]), 32'd155);
        check("sw_led3", 32'(led_out_a[3]), 32'd0);
        led_in = 4'b1111;

        // ---------------- PWM duty on the slow instance ----------------------
        led_in_c = 4'b1110;
        tick(3);
        check("c_full", 32'(dut_c.bri[0]), 32'd255);
        led_in_c = 4'b1111;
        lvl[0] = 8'd191;
        lvl[1] = 8'd127;
        lvl[2] = 8'd63;
        lvl[3] = 8'd0;
        for (int i = 0; i < 4; i++) begin
            wait_c_value(lvl[i]);
            check("c_level", 32'(dut_c.bri[0]), 32'(lvl[i]));
            tick(2);
            count_lows_c(lows);
            check("c_duty", 32'(lows), 32'(lvl[i]));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/led_fade_pwm.md
Name: led_fade_pwm

Overview:
- Downstream stage of the running-light generator. Consumes its 4-bit active-low one-hot LED pattern and drives the board LEDs.
- Each channel lights at full brightness while its input is active. On release it fades out linearly through PWM, leaving an afterglow trail behind the moving light.
- A bypass mode passes the pattern straight through, registered.

Parameters:
PWM_W, 8, brightness/PWM counter width; PWM period = 2^PWM_W - 1 cycles (255 at default)
DECAY_MAX, 24'd97_655, decay prescaler terminal count; one decay tick every DECAY_MAX+1 cycles (~0.5 s full fade at 50 MHz)
DECAY_STEP, 8'd1, brightness decrement applied per decay tick (PWM_W bits)

Ports:
sys_clk    input   1  system clock, 50 MHz
sys_rst_n  input   1  asynchronous active-low reset
led_in     input   4  LED pattern from upstream, active-low, synchronous to sys_clk
fade_en    input   1  1 = fade/PWM mode, 0 = bypass (registered pass-through)
led_out    output  4  LED drive, active-low, registered

Behaviour:
- Reset is applied by sys_rst_n, asynchronous, active-low, on clock sys_clk. Reset forces every register to its reset value immediately, including mid-fade. No reset-release sequencing.
- led_in_d[3:0]: led_in registered once each cycle. Reset 4'b1111.
- pwm_cnt[PWM_W-1:0]: free-running, counts 0 to 2^PWM_W-2, then wraps to 0 (254 to 0 at default). Reset 0.
- decay_cnt[23:0]: counts 0 to DECAY_MAX, then wraps to 0. Reset 0.
- decay_tick: combinational, high exactly in cycles where decay_cnt == DECAY_MAX. One-cycle pulse per prescaler period.
- bri[i][PWM_W-1:0], i = 0..3: per-channel brightness. Reset 0. Update per clock, priority order:
  1. led_in_d[i]==0: bri[i] <= all-ones (255). Re-triggers mid-fade with no delay.
  2. else decay_tick && bri[i] >= DECAY_STEP: bri[i] <= bri[i] - DECAY_STEP.
  3. else decay_tick: bri[i] <= 0. Saturating; never wraps below 0.
  4. else hold.
- Brightness always updates regardless of fade_en. Toggling fade_en never resets or jumps any fade state.
- led_out[i], registered. Reset 1 (all LEDs off).
  - fade_en==1: led_out[i] <= ~(bri[i] > pwm_cnt).
  - fade_en==0: led_out[i] <= led_in_d[i].
- Duty cycle: bri=255 gives 100% on (pwm_cnt never exceeds 254). bri=0 gives 0% on. Otherwise exactly bri cycles low per 255-cycle PWM period.
- Latency, input edge at clock k:
  - led_in_d updates at k+1.
  - bri = 255 at k+2.
  - led_out low at k+3 in fade mode; bypass shows the same change at k+2.
- Release latency: the first decrement occurs on the first decay_tick after led_in_d[i] returns to 1. Full fade takes ceil(255/DECAY_STEP) ticks.
- Simultaneous events:
  - Multiple channels active together are handled independently.
  - led_in_d[i]==0 coinciding with decay_tick resolves to 255 (priority 1).
- All four channels share pwm_cnt and decay_cnt. No per-channel phase offset.
- All arithmetic is unsigned and PWM_W bits wide. The comparison bri > pwm_cnt is unsigned.

Test Plan:
Common setup for scenarios 3-6: PWM_W=8, DECAY_MAX=3, DECAY_STEP=64.
1. Assert sys_rst_n=0 mid-run, including while led_in=4'b0000 -> led_out=4'b1111 in the same cycle. After release, all bri=0, pwm_cnt=0, decay_cnt=0, and led_out stays 1111 until input activity.
2. fade_en=1, led_in=4'b1110 held for 600 cycles -> led_out[0]=0 from the third clock after the input edge, continuously low. led_out[3:1]=3'b111 throughout.
3. After scenario 2, set led_in=4'b1111 -> bri[0] steps 255→191→127→63→0, one step every 4 cycles. Low-cycle count of led_out[0] within a PWM period equals the current bri. After the final tick, led_out[0] stays 1.
4. Re-trigger: during scenario 3 at bri[0]=127, drive led_in[0]=0 for one cycle -> bri[0] returns to 255 two cycles later, then decay restarts from 255.
5. Saturation: DECAY_STEP=100 -> bri decays 255→155→55→0, then holds 0 (no wrap to 211).
6. Bypass: fade_en=0, drive led_in sequence 1110, 1101, 1011, 0111 -> led_out reproduces the same sequence delayed 2 cycles. Switch to fade_en=1 mid-sequence -> trailing channels show partial PWM duty immediately, with no brightness discontinuity.
